// File: rtl/enemy_shot_sched_pkg.sv
// Shared constants for the enemy shot scheduler:
// coordinate width, default tuning values and FSM state codes.
package enemy_shot_sched_pkg;

  localparam int CW = 12;

  localparam int TICK_LIM_D  = 1000000;
  localparam int STEP_PX_D   = 4;
  localparam int Y_MAX_D     = 600;
  localparam int MUZZLE_DY_D = 20;
  localparam int COOLDOWN_D  = 50;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  typedef logic [CW-1:0] coord_t;

endpackage

// File: rtl/enemy_shot_sched_rr_arbiter.sv
// N-input round-robin arbiter: one-hot grant, first requester
// at or after the pointer; pointer moves past the winner on upd.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          upd,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] ptr;

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx -= N;
      if (!any && req[idx]) begin
        any         = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_idx     = IW'(idx);
      end
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (upd && any) begin
      ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/enemy_shot_sched.sv
// Enemy fire scheduler: round-robin grant of shot requests into a
// pool of bullet slots, stepped downward on a divided tick.
module enemy_shot_sched
  import enemy_shot_sched_pkg::*;
#(
  parameter int N_EN      = 3,
  parameter int N_SLOT    = 2,
  parameter int TICK_LIM  = TICK_LIM_D,
  parameter int STEP_PX   = STEP_PX_D,
  parameter int Y_MAX     = Y_MAX_D,
  parameter int MUZZLE_DY = MUZZLE_DY_D,
  parameter int COOLDOWN  = COOLDOWN_D
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_EN-1:0]      req,
  input  logic [CW*N_EN-1:0]   xpos_in,
  input  logic [CW*N_EN-1:0]   ypos_in,
  input  logic [N_SLOT-1:0]    hit,
  output logic [N_EN-1:0]      ack,
  output logic [N_SLOT-1:0]    blt_vld,
  output logic [CW*N_SLOT-1:0] blt_x,
  output logic [CW*N_SLOT-1:0] blt_y
);

  localparam int TW = $clog2(TICK_LIM);
  localparam int DW = $clog2(COOLDOWN + 2);
  localparam int SW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int IW = (N_EN > 1) ? $clog2(N_EN) : 1;

  logic [TW-1:0]     cnt;
  logic              tick;
  logic [1:0]        state;
  logic [DW-1:0]     cd;
  logic [N_EN-1:0]   gnt;
  logic [IW-1:0]     widx;
  logic              any;
  logic              load;
  logic              free_any;
  logic [SW-1:0]     fidx;
  coord_t            wx;
  coord_t            wy;
  logic [N_SLOT-1:0] vld;
  coord_t            sx [N_SLOT];
  coord_t            sy [N_SLOT];
  coord_t            ny [N_SLOT];

  assign tick = en && (cnt == TW'(TICK_LIM-1));

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  rr_arbiter #(.N(N_EN), .IW(IW)) u_arb (
    .pclk    (pclk),
    .rst     (rst),
    .req     (req),
    .upd     (load),
    .gnt     (gnt),
    .gnt_idx (widx),
    .any     (any)
  );

  always_comb begin
    free_any = 1'b0;
    fidx     = '0;
    for (int j = N_SLOT-1; j >= 0; j--) begin
      if (!vld[j]) begin
        free_any = 1'b1;
        fidx     = SW'(j);
      end
    end
  end

  assign load = (state == S_GRANT) && en && any && free_any;
  assign wx   = xpos_in[int'(widx)*CW +: CW];
  assign wy   = ypos_in[int'(widx)*CW +: CW] + coord_t'(MUZZLE_DY);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cd    <= '0;
      ack   <= '0;
    end else begin
      ack <= '0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (en && |req && free_any && cd == '0)
            state <= S_GRANT;
        end
        (state == S_GRANT): begin
          if (load) begin
            ack   <= gnt;
            cd    <= DW'(COOLDOWN);
            state <= S_HOLD;
          end else begin
            state <= S_IDLE;
          end
        end
        (state == S_HOLD): begin
          if (cd == '0) state <= S_IDLE;
          else if (tick) cd <= cd - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < N_SLOT; j++)
      ny[j] = sy[j] + coord_t'(STEP_PX);
  end

  // Load beats hit beats step; a freed slot keeps its last x/y.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int j = 0; j < N_SLOT; j++) begin
        sx[j] <= '0;
        sy[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N_SLOT; j++) begin
        if (load && fidx == SW'(j)) begin
          vld[j] <= 1'b1;
          sx[j]  <= wx;
          sy[j]  <= wy;
        end else if (vld[j] && hit[j]) begin
          vld[j] <= 1'b0;
        end else if (vld[j] && tick) begin
          sy[j] <= ny[j];
          if (ny[j] >= coord_t'(Y_MAX)) vld[j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    blt_x = '0;
    blt_y = '0;
    for (int j = 0; j < N_SLOT; j++) begin
      blt_x[j*CW +: CW] = sx[j];
      blt_y[j*CW +: CW] = sy[j];
    end
  end

  assign blt_vld = vld;

endmodule

// File: tb/tb_enemy_shot_sched.sv
// Scoreboard bench for enemy_shot_sched: grants, stepping,
// exit, hit priority, freeze and async reset.
module tb_enemy_shot_sched;

  localparam int TL = 8;

  typedef struct {
    int         en;
    int         slot;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  req = '0;
  logic [35:0] xpos = '0;
  logic [35:0] ypos = '0;
  logic [1:0]  hit = '0;
  logic [2:0]  ack;
  logic [1:0]  blt_vld;
  logic [23:0] blt_x;
  logic [23:0] blt_y;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mcnt = 0;
  int   ntick = 0;

  enemy_shot_sched #(
    .N_EN(3), .N_SLOT(2), .TICK_LIM(TL), .STEP_PX(4),
    .Y_MAX(600), .MUZZLE_DY(20), .COOLDOWN(1)
  ) dut (
    .pclk    (pclk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .xpos_in (xpos),
    .ypos_in (ypos),
    .hit     (hit),
    .ack     (ack),
    .blt_vld (blt_vld),
    .blt_x   (blt_x),
    .blt_y   (blt_y)
  );

  always #5 pclk = ~pclk;

  // Reference tick divider: mcnt phase and running tick count.
  always @(posedge pclk or negedge rst) begin
    if (!rst) begin
      mcnt <= 0;
    end else if (en) begin
      if (mcnt == TL-1) begin
        mcnt  <= 0;
        ntick <= ntick + 1;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic set_pos(input int i, input int x, input int y);
    xpos[12*i +: 12] = 12'(x);
    ypos[12*i +: 12] = 12'(y);
  endtask

  task automatic apply_reset();
    @(negedge pclk);
    rst = 1'b0;
    en  = 1'b1;
    req = '0;
    hit = '0;
    sbq.delete();
    repeat (2) @(negedge pclk);
    rst = 1'b1;
  endtask

  task automatic wait_ack(output int cyc);
    exp_t e;
    logic [2:0] ea;
    bit got;
    got = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge pclk);
      if (ack !== 3'b000) begin
        got = 1'b1;
        cyc = i;
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL ack_timeout: ack=%b after 40 cycles, required a grant", ack);
    end else if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL ack_unexpected: ack=%b, required none", ack);
    end else begin
      e  = sbq.pop_front();
      ea = 3'b001 << e.en;
      if (ack !== ea) begin
        n_bad++;
        $display("FAIL ack_winner: got %b required %b", ack, ea);
      end
      n_cmp++;
      if (blt_vld[e.slot] !== 1'b1) begin
        n_bad++;
        $display("FAIL load_vld: slot %0d vld=%b required 1", e.slot, blt_vld[e.slot]);
      end
      n_cmp++;
      if (blt_x[12*e.slot +: 12] !== e.x) begin
        n_bad++;
        $display("FAIL load_x: slot %0d got %0d required %0d", e.slot, blt_x[12*e.slot +: 12], e.x);
      end
      n_cmp++;
      if (blt_y[12*e.slot +: 12] !== e.y) begin
        n_bad++;
        $display("FAIL load_y: slot %0d got %0d required %0d", e.slot, blt_y[12*e.slot +: 12], e.y);
      end
    end
  endtask

  task automatic wait_ticks(input int n);
    int t;
    t = ntick;
    for (int i = 0; i < n*TL*2 + 4; i++) begin
      if (ntick >= t + n) break;
      @(negedge pclk);
    end
    if (ntick < t + n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: saw %0d ticks required %0d", ntick - t, n);
    end
  endtask

  task automatic pulse_hit(input logic [1:0] h);
    @(negedge pclk);
    hit = h;
    @(negedge pclk);
    hit = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge pclk);
    n_cmp++;
    if (ack !== 3'b000) begin
      n_bad++; $display("FAIL rst_ack: got %b required 000", ack);
    end
    n_cmp++;
    if (blt_vld !== 2'b00) begin
      n_bad++; $display("FAIL rst_vld: got %b required 00", blt_vld);
    end
    n_cmp++;
    if (blt_x !== 24'h0) begin
      n_bad++; $display("FAIL rst_x: got %h required 0", blt_x);
    end
    n_cmp++;
    if (blt_y !== 24'h0) begin
      n_bad++; $display("FAIL rst_y: got %h required 0", blt_y);
    end
  endtask

  task automatic test_single();
    int cyc;
    int t0;
    apply_reset();
    set_pos(0, 100, 70);
    sbq.push_back('{0, 0, 12'd100, 12'd90});
    req = 3'b001;
    wait_ack(cyc);
    t0 = ntick;
    n_cmp++;
    if (cyc != 2) begin
      n_bad++; $display("FAIL grant_latency: got %0d cycles required 2", cyc);
    end
    req = 3'b000;
    @(negedge pclk);
    n_cmp++;
    if (ack !== 3'b000) begin
      n_bad++; $display("FAIL ack_pulse: got %b required 000", ack);
    end
    wait_ticks(3);
    n_cmp++;
    if (blt_y[11:0] !== 12'(90 + 4*(ntick - t0))) begin
      n_bad++; $display("FAIL step_y: got %0d required %0d", blt_y[11:0], 90 + 4*(ntick - t0));
    end
  endtask

  task automatic test_fairness();
    int cyc;
    int bad;
    apply_reset();
    set_pos(0, 200, 100);
    set_pos(1, 210, 150);
    set_pos(2, 220, 200);
    sbq.push_back('{0, 0, 12'd200, 12'd120});
    sbq.push_back('{1, 1, 12'd210, 12'd170});
    sbq.push_back('{2, 0, 12'd220, 12'd220});
    sbq.push_back('{0, 1, 12'd200, 12'd120});
    req = 3'b111;
    wait_ack(cyc);
    wait_ack(cyc);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge pclk);
      if (ack !== 3'b000 || blt_vld !== 2'b11) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL pool_full_wait: %0d bad cycles, last ack=%b vld=%b required 000/11", bad, ack, blt_vld);
    end
    pulse_hit(2'b01);
    wait_ack(cyc);
    pulse_hit(2'b10);
    wait_ack(cyc);
    req = 3'b000;
  endtask

  task automatic test_exit();
    int cyc;
    apply_reset();
    set_pos(0, 50, 578);
    sbq.push_back('{0, 0, 12'd50, 12'd598});
    req = 3'b001;
    wait_ack(cyc);
    req = 3'b000;
    wait_ticks(1);
    n_cmp++;
    if (blt_vld[0] !== 1'b0) begin
      n_bad++; $display("FAIL exit_vld: got %b required 0", blt_vld[0]);
    end
    n_cmp++;
    if (blt_y[11:0] !== 12'd602) begin
      n_bad++; $display("FAIL exit_y: got %0d required 602", blt_y[11:0]);
    end
    n_cmp++;
    if (blt_x[11:0] !== 12'd50) begin
      n_bad++; $display("FAIL exit_x: got %0d required 50", blt_x[11:0]);
    end
  endtask

  task automatic test_hit_vs_step();
    int cyc;
    int t0;
    logic [11:0] yexp;
    apply_reset();
    set_pos(0, 100, 70);
    sbq.push_back('{0, 0, 12'd100, 12'd90});
    req = 3'b001;
    wait_ack(cyc);
    t0 = ntick;
    req = 3'b000;
    pulse_hit(2'b10);
    n_cmp++;
    if (blt_vld !== 2'b01 || blt_x[23:12] !== 12'd0 || blt_y[23:12] !== 12'd0) begin
      n_bad++; $display("FAIL hit_empty: vld=%b x1=%0d y1=%0d required 01/0/0", blt_vld, blt_x[23:12], blt_y[23:12]);
    end
    for (int i = 0; i < 2*TL; i++) begin
      if (mcnt == TL-1) break;
      @(negedge pclk);
    end
    yexp = 12'(90 + 4*(ntick - t0));
    hit = 2'b01;
    @(posedge pclk);
    #1;
    n_cmp++;
    if (blt_vld[0] !== 1'b0) begin
      n_bad++; $display("FAIL hit_tick_vld: got %b required 0", blt_vld[0]);
    end
    n_cmp++;
    if (blt_y[11:0] !== yexp) begin
      n_bad++; $display("FAIL hit_tick_y: got %0d required %0d", blt_y[11:0], yexp);
    end
    @(negedge pclk);
    hit = '0;
  endtask

  task automatic test_en_freeze();
    int cyc;
    int t0;
    int bad;
    logic [11:0] yexp;
    apply_reset();
    set_pos(0, 100, 70);
    set_pos(1, 300, 150);
    sbq.push_back('{0, 0, 12'd100, 12'd90});
    req = 3'b001;
    wait_ack(cyc);
    t0 = ntick;
    req = 3'b000;
    wait_ticks(2);
    yexp = 12'(90 + 4*(ntick - t0));
    n_cmp++;
    if (blt_y[11:0] !== yexp) begin
      n_bad++; $display("FAIL pre_freeze_y: got %0d required %0d", blt_y[11:0], yexp);
    end
    for (int i = 0; i < 2*TL; i++) begin
      if (mcnt == 3) break;
      @(negedge pclk);
    end
    en  = 1'b0;
    req = 3'b010;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge pclk);
      if (ack !== 3'b000 || blt_y[11:0] !== yexp || blt_vld !== 2'b01) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL freeze: %0d bad cycles, ack=%b y0=%0d vld=%b required 000/%0d/01", bad, ack, blt_y[11:0], yexp, blt_vld);
    end
    sbq.push_back('{1, 1, 12'd300, 12'd170});
    en = 1'b1;
    wait_ack(cyc);
    req = 3'b000;
    for (int i = 0; i < 2*TL; i++) begin
      if (mcnt == TL-1) break;
      @(negedge pclk);
    end
    n_cmp++;
    if (blt_y[11:0] !== yexp) begin
      n_bad++; $display("FAIL resume_pre_tick: got %0d required %0d", blt_y[11:0], yexp);
    end
    @(posedge pclk);
    #1;
    n_cmp++;
    if (blt_y[11:0] !== yexp + 12'd4) begin
      n_bad++; $display("FAIL resume_tick: got %0d required %0d", blt_y[11:0], yexp + 12'd4);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    apply_reset();
    set_pos(0, 100, 70);
    sbq.push_back('{0, 0, 12'd100, 12'd90});
    req = 3'b001;
    wait_ack(cyc);
    req = 3'b000;
    @(negedge pclk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (blt_vld !== 2'b00) begin
      n_bad++; $display("FAIL async_vld: got %b required 00", blt_vld);
    end
    n_cmp++;
    if (blt_x !== 24'h0 || blt_y !== 24'h0) begin
      n_bad++; $display("FAIL async_xy: x=%h y=%h required 0/0", blt_x, blt_y);
    end
    n_cmp++;
    if (ack !== 3'b000) begin
      n_bad++; $display("FAIL async_ack: got %b required 000", ack);
    end
    @(negedge pclk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_exit();
    test_hit_vs_step();
    test_en_freeze();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
